// File: rtl/snake_pkg.sv
// Shared types and defaults for the snake game datapath.
package snake_pkg;

    typedef enum logic [1:0] {
        MENU  = 2'd0,
        GAME  = 2'd1,
        ERROR = 2'd2
    } game_mode;

    localparam int unsigned ERR_FRAMES_DEF  = 120;
    localparam int unsigned OVER_FRAMES_DEF = 180;

endpackage

// File: rtl/game_mode_ctrl_if.sv
// Control and status bundle between the mode controller and its neighbours.
interface game_mode_ctrl_if;
    import snake_pkg::*;

    logic     vblnk;
    logic     start;
    logic     link_ok;
    logic     game_over;
    game_mode mode;
    logic     game_rst;
    logic     frame_tick;

    modport master (
        output vblnk, start, link_ok, game_over,
        input  mode, game_rst, frame_tick
    );

    modport slave (
        input  vblnk, start, link_ok, game_over,
        output mode, game_rst, frame_tick
    );

endinterface

// File: rtl/edge_det.sv
// Registered rising-edge detector; RST_VAL=1 suppresses an edge for lines held high through reset.
module edge_det #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise_c
);

    logic d_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) d_q <= RST_VAL;
        else      d_q <= d;
    end

    assign rise_c = d & ~d_q;

endmodule

// File: rtl/game_mode_ctrl.sv
// Frame-synchronous MENU/GAME/ERROR sequencer; mode changes commit only on the vblnk rise.
module game_mode_ctrl
    import snake_pkg::*;
#(
    parameter int unsigned ERR_FRAMES  = ERR_FRAMES_DEF,
    parameter int unsigned OVER_FRAMES = OVER_FRAMES_DEF
) (
    input  logic              clk,
    input  logic              rst,
    game_mode_ctrl_if.slave   bus
);

    localparam int unsigned CNT_MAX = (ERR_FRAMES > OVER_FRAMES) ? ERR_FRAMES : OVER_FRAMES;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        ST_MENU  = 2'd0,
        ST_GAME  = 2'd1,
        ST_OVER  = 2'd2,
        ST_ERROR = 2'd3
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            start_pend;
    logic            err_pend;
    logic            over_pend;
    logic            tick;
    logic            start_rise;

    edge_det #(.RST_VAL(1'b1)) u_vblnk_det (
        .clk    (clk),
        .rst    (rst),
        .d      (bus.vblnk),
        .rise_c (tick)
    );

    edge_det #(.RST_VAL(1'b1)) u_start_det (
        .clk    (clk),
        .rst    (rst),
        .d      (bus.start),
        .rise_c (start_rise)
    );

    assign bus.frame_tick = tick;

    // Flags are captured every cycle; any transition below clears them, overriding the capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_MENU;
            bus.mode     <= MENU;
            bus.game_rst <= 1'b0;
            cnt          <= '0;
            start_pend   <= 1'b0;
            err_pend     <= 1'b0;
            over_pend    <= 1'b0;
        end else begin
            bus.game_rst <= 1'b0;

            if (state == ST_MENU && start_rise)                       start_pend <= 1'b1;
            if ((state == ST_GAME || state == ST_OVER) && !bus.link_ok) err_pend   <= 1'b1;
            if (state == ST_GAME && bus.game_over)                    over_pend  <= 1'b1;

            if (tick) begin
                unique case (state)
                    ST_MENU: begin
                        if (start_pend) begin
                            start_pend <= 1'b0;
                            err_pend   <= 1'b0;
                            over_pend  <= 1'b0;
                            if (bus.link_ok) begin
                                state        <= ST_GAME;
                                bus.mode     <= GAME;
                                bus.game_rst <= 1'b1;
                                cnt          <= '0;
                            end else begin
                                state    <= ST_ERROR;
                                bus.mode <= ERROR;
                                cnt      <= CW'(ERR_FRAMES);
                            end
                        end
                    end
                    ST_GAME: begin
                        if (err_pend || over_pend) begin
                            start_pend <= 1'b0;
                            err_pend   <= 1'b0;
                            over_pend  <= 1'b0;
                            if (err_pend) begin
                                state    <= ST_ERROR;
                                bus.mode <= ERROR;
                                cnt      <= CW'(ERR_FRAMES);
                            end else begin
                                state <= ST_OVER;
                                cnt   <= CW'(OVER_FRAMES);
                            end
                        end
                    end
                    ST_OVER: begin
                        if (err_pend) begin
                            state      <= ST_ERROR;
                            bus.mode   <= ERROR;
                            cnt        <= CW'(ERR_FRAMES);
                            start_pend <= 1'b0;
                            err_pend   <= 1'b0;
                            over_pend  <= 1'b0;
                        end else if (cnt == CW'(1)) begin
                            state      <= ST_MENU;
                            bus.mode   <= MENU;
                            cnt        <= '0;
                            start_pend <= 1'b0;
                            err_pend   <= 1'b0;
                            over_pend  <= 1'b0;
                        end else if (cnt != '0) begin
                            cnt <= cnt - CW'(1);
                        end
                    end
                    ST_ERROR: begin
                        if (cnt != '0) begin
                            cnt <= cnt - CW'(1);
                        end else if (bus.link_ok) begin
                            state      <= ST_MENU;
                            bus.mode   <= MENU;
                            start_pend <= 1'b0;
                            err_pend   <= 1'b0;
                            over_pend  <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/game_mode_ctrl.md
# game_mode_ctrl

Frame-synchronous controller that sequences the display `mode` (`game_mode`) consumed by the draw stage. It turns user start requests, link status and game-over events into MENU / GAME / ERROR transitions. Mode changes are committed only at the start of vertical blanking, so a visible frame is never split between two pictures. It also issues the one-cycle reset pulse for game logic on entry to GAME.

## Interface
Parameters:
- `ERR_FRAMES`, default 120: minimum number of frames the ERROR picture is held; must be ≥1.
- `OVER_FRAMES`, default 180: number of frames the final game picture is held after game over; must be ≥1.

Ports:
- `clk`  in  1  pixel clock; single clock domain.
- `rst`  in  1  reset, asynchronous, active-low (0 = reset).
- `vblnk`  in  1  vertical blank from VGA timing; level.
- `start`  in  1  start request from input decoder; level, edge-detected internally.
- `link_ok`  in  1  opponent link healthy; level.
- `game_over`  in  1  game end from game logic; level or pulse.
- `mode`  out  `game_mode`  registered display mode for the draw stage.
- `game_rst`  out  1  one-cycle pulse on entry to GAME.
- `frame_tick`  out  1  one-cycle pulse at the rising edge of `vblnk`.

## Operation
- `frame_tick = vblnk & ~vblnk_q`. Every state transition and every countdown step happens only on cycles where `frame_tick` = 1.
- Start edge: `start & ~start_q`. It is latched into `start_pend` only in ST_MENU. In all other states it is ignored and is not latched.
- `link_ok` = 0 on any cycle in ST_GAME or ST_OVER sets `err_pend`.
- `game_over` = 1 on any cycle in ST_GAME sets `over_pend`.
- A pending flag is cleared on the tick that consumes it. All pending flags are cleared on every state change.

States (internal enum):
- ST_MENU (`mode`=MENU), on tick with `start_pend` set:
  - if `link_ok` = 1: go to ST_GAME and assert `game_rst`.
  - otherwise: go to ST_ERROR with `cnt`=ERR_FRAMES.
- ST_GAME (`mode`=GAME), on tick:
  - `err_pend` set: go to ST_ERROR with `cnt`=ERR_FRAMES. This has priority over `over_pend`.
  - otherwise `over_pend` set: go to ST_OVER with `cnt`=OVER_FRAMES.
- ST_OVER (`mode`=GAME, picture frozen by game logic), on tick:
  - `err_pend` set: go to ST_ERROR with `cnt`=ERR_FRAMES.
  - otherwise, if `cnt`==1: go to ST_MENU.
  - otherwise decrement `cnt`.
- ST_ERROR (`mode`=ERROR), on tick:
  - if `cnt`≠0: decrement `cnt`.
  - if `cnt`==0 and `link_ok`=1: go to ST_MENU.
  - if `cnt`==0 and `link_ok`=0: hold, with `cnt` saturated at 0.

Arithmetic and encoding:
- `cnt` width is `$clog2(max(ERR_FRAMES,OVER_FRAMES)+1)`. Decrement never wraps below 0.
- `mode` is decoded from the state inside the same register update; it is never driven combinationally from inputs.

## Timing
- Reset values: state ST_MENU, `mode`=MENU, `game_rst`=0, `frame_tick`=0, `cnt`=0, all pending flags 0, `start_q`=1, `vblnk_q`=1. The `_q` values of 1 mean a line held high through reset produces no spurious edge.
- Deassertion of reset mid-frame has no effect on state. The first tick comes at the next real `vblnk` rise.
- `frame_tick` is high in the cycle `vblnk` is first seen high.
- `mode` and `game_rst` update on that same clock edge and are visible one cycle after `vblnk` rises at the input.
- `game_rst` is high for exactly one cycle, coincident with the first cycle of `mode`=GAME.
- Start-to-GAME latency: from the start edge to the next tick, at most one frame plus one cycle.
- Simultaneous events:
  - A start edge in the same cycle as a tick is latched and consumed on the next tick.
  - `link_ok` falling in the tick cycle of ST_GAME counts for the next tick.
- Reset asserted mid-operation immediately forces all reset values. No frame alignment is required.

## Structure
- `game_mode` (MENU, GAME, ERROR) remains in `snake_pkg`.
- Add `ERR_FRAMES_DEF` and `OVER_FRAMES_DEF` constants to `snake_pkg`.
- The state enum is local to the module.
- One sub-module, `edge_det`, is instantiated twice (for `vblnk` and `start`). It is a registered rising-edge detector with a reset-value parameter.

## Test plan
- Reset held low with `vblnk`=1, then released → no `frame_tick`, `mode`=MENU, `game_rst`=0 until the next `vblnk` rise.
- MENU, `link_ok`=1, `start` pulse mid-frame → `mode`=GAME and one-cycle `game_rst` one cycle after the next `vblnk` rise, and not before.
- MENU, `link_ok`=0, start → ERROR; after ERR_FRAMES=3 ticks with `link_ok` raised → MENU. With `link_ok` still 0 → ERROR held indefinitely.
- GAME, `game_over` and a `link_ok` drop in the same frame → ERROR, not OVER.
- GAME, `game_over` only, OVER_FRAMES=2 → `mode` stays GAME for 2 ticks, then MENU. Start presses during GAME and OVER do not cause a restart.
- Reset asserted mid-ERROR countdown → immediate MENU, `cnt`=0, pending flags cleared.
